// File: rtl/snake_defs.sv
// Direction encoding shared by the key decoder and the snake movement logic.
package snake_defs;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Bit positions of each key inside the 4-bit key_pulse vector.
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int NUM_KEYS  = 4;

    // Opposite pairs differ only in bit 0: UP/DOWN and LEFT/RIGHT.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One raw key: two-flop synchronizer, hold-time debouncer and press strobe.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_p0;
    logic             key_p1;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p0 <= 1'b0;
            key_p1 <= 1'b0;
        end else begin
            key_p0 <= key;
            key_p1 <= key_p0;
        end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (key_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= key_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One-cycle strobe on a stable rising edge; releases and long holds give nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/key_direction_decoder.sv
// Turns four raw direction keys into a committed snake heading, one change per game tick.
module key_direction_decoder
    import snake_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       tick,
    input  logic       hold,
    output logic [3:0] key_pulse,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic       pending_valid
);

    logic [NUM_KEYS-1:0] raw_keys;
    dir_t                dir_q;
    dir_t                pending;
    dir_t                req;
    logic                any_press;
    logic                accept;
    logic                commit;

    assign raw_keys = {key_right, key_left, key_down, key_up};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debouncer (
            .clk   (clk),
            .rst   (rst),
            .key   (raw_keys[i]),
            .pulse (key_pulse[i])
        );
    end

    // Pick the requested heading (up > down > left > right) and decide whether it may be queued.
    always_comb begin
        req       = DIR_UP;
        any_press = |key_pulse;
        if (key_pulse[KEY_UP])         req = DIR_UP;
        else if (key_pulse[KEY_DOWN])  req = DIR_DOWN;
        else if (key_pulse[KEY_LEFT])  req = DIR_LEFT;
        else if (key_pulse[KEY_RIGHT]) req = DIR_RIGHT;
        // Checked against the heading before any same-cycle commit.
        accept = any_press && !hold && (req != dir_q) && (req != opposite(dir_q));
        commit = tick && !hold && pending_valid;
    end

    // Pending queue (last accepted press wins) and tick-driven commit of the heading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q         <= DIR_RIGHT;
            pending       <= DIR_RIGHT;
            pending_valid <= 1'b0;
            dir_changed   <= 1'b0;
        end else begin
            dir_changed <= commit;
            if (commit) begin
                dir_q <= pending;
            end
            if (accept) begin
                pending       <= req;
                pending_valid <= 1'b1;
            end else if (commit) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign dir = dir_q;

endmodule

// File: tb/tb_key_direction_decoder.sv
// Self-checking bench: directed vectors, corner sequences and random keys against a reference model.
module tb_key_direction_decoder;

    localparam int D     = 200;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_up, key_down, key_left, key_right;
    logic       tick, hold;
    logic [3:0] key_pulse;
    logic [1:0] dir;
    logic       dir_changed;
    logic       pending_valid;

    int checks = 0;
    int errors = 0;
    logic [3:0] seen;

    key_direction_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_left      (key_left),
        .key_right     (key_right),
        .tick          (tick),
        .hold          (hold),
        .key_pulse     (key_pulse),
        .dir           (dir),
        .dir_changed   (dir_changed),
        .pending_valid (pending_valid)
    );

    always #5 clk = ~clk;

    // Reference model: keys are indexed by their heading code (UP=0..RIGHT=3).
    int   opp [4] = '{1, 0, 3, 2};
    int   m_sync0 [4];
    int   m_sync1 [4];
    int   m_stable [4];
    int   m_streak [4];
    int   m_rose_last [4];
    logic [3:0] m_pulse;
    int   m_dir, m_pend;
    bit   m_pv, m_dchg;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sync0[i] = 0; m_sync1[i] = 0; m_stable[i] = 0;
            m_streak[i] = 0; m_rose_last[i] = 0;
        end
        m_pulse = 4'b0; m_dir = 3; m_pend = 3; m_pv = 0; m_dchg = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        int  req, old_pend, s, rose;
        bit  accept, commit;
        raw = {key_right, key_left, key_down, key_up};
        req = -1;
        for (int i = 0; i < 4; i++) if (m_pulse[i] && req < 0) req = i;
        commit   = tick && !hold && m_pv;
        accept   = (req >= 0) && !hold && (req != m_dir) && (req != opp[m_dir]);
        old_pend = m_pend;
        m_dchg   = commit;
        if (accept) begin m_pend = req; m_pv = 1; end
        else if (commit) m_pv = 0;
        if (commit) m_dir = old_pend;
        for (int i = 0; i < 4; i++) begin
            s = m_sync1[i];
            rose = 0;
            if (s == m_stable[i]) m_streak[i] = 0;
            else begin
                m_streak[i]++;
                if (m_streak[i] == D) begin
                    m_stable[i] = s; m_streak[i] = 0; rose = s;
                end
            end
            m_pulse[i]     = m_rose_last[i][0];
            m_rose_last[i] = rose;
            m_sync1[i]     = m_sync0[i];
            m_sync0[i]     = int'(raw[i]);
        end
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (key_pulse !== m_pulse || dir !== 2'(m_dir) || dir_changed !== m_dchg || pending_valid !== m_pv) begin
            errors++;
            $display("FAIL %s t=%0t got pulse=%b dir=%0d chg=%b pv=%b expected pulse=%b dir=%0d chg=%b pv=%b",
                     tag, $time, key_pulse, dir, dir_changed, pending_valid, m_pulse, m_dir, m_dchg, m_pv);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic cycle();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        seen = seen | key_pulse;
        compare_model("model");
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_right, key_left, key_down, key_up} = k;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_keys(4'b0); tick = 1'b0; hold = 1'b0;
        model_reset();
        #2;
        compare_model("reset_async");
        run(3);
        rst = 1'b0;
        seen = 4'b0;
    endtask

    task automatic press(input logic [3:0] k);
        set_keys(k);
        run(D + 5);
        set_keys(4'b0);
        run(D + 5);
    endtask

    task automatic do_tick(input logic h);
        hold = h; tick = 1'b1;
        cycle();
        tick = 1'b0; hold = 1'b0;
    endtask

    typedef struct {
        logic [3:0] keys;
        logic       hold_press;
        logic       do_tick;
        logic       hold_tick;
        int         exp_dir;
        int         exp_pv;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int first, cnt, dur [4];
        bit found;
        logic [3:0] kv;

        rst = 1'b1; set_keys(4'b0); tick = 1'b0; hold = 1'b0; seen = 4'b0;
        #2;
        check("reset_dir", int'(dir), 3);
        check("reset_pv", int'(pending_valid), 0);
        check("reset_pulse", int'(key_pulse), 0);
        check("reset_chg", int'(dir_changed), 0);
        do_reset();

        // Press latency and first commit.
        key_up = 1'b1;
        first = -1; cnt = 0;
        for (int n = 0; n < 300; n++) begin
            cycle();
            if (key_pulse[0]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        check("up_latency_edge", first, D + 2);
        check("up_pulse_count", cnt, 1);
        check("up_pending", int'(pending_valid), 1);
        key_up = 1'b0;
        run(D + 5);
        do_tick(1'b0);
        check("up_commit_dir", int'(dir), 0);
        check("up_commit_chg", int'(dir_changed), 1);
        cycle();
        check("up_chg_one_cycle", int'(dir_changed), 0);

        // Glitch shorter than the debounce window.
        do_reset();
        key_left = 1'b1;
        run(150);
        key_left = 1'b0;
        run(D + 10);
        check("glitch_no_pulse", int'(seen), 0);
        check("glitch_pv", int'(pending_valid), 0);
        check("glitch_dir", int'(dir), 3);

        // Table of press/tick vectors starting from dir=RIGHT.
        vecs[0]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 3, 0};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 3, 1};
        vecs[2]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 1, 0};
        vecs[3]  = '{4'b1000, 1'b0, 1'b1, 1'b0, 3, 0};
        vecs[4]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[5]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 2, 0};
        vecs[6]  = '{4'b1001, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[7]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[8]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[9]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[10] = '{4'b1000, 1'b0, 1'b1, 1'b1, 0, 1};
        vecs[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 3, 0};
        do_reset();
        for (int v = 0; v < 12; v++) begin
            seen = 4'b0;
            hold = vecs[v].hold_press;
            set_keys(vecs[v].keys);
            run(D + 5);
            set_keys(4'b0);
            hold = 1'b0;
            run(D + 5);
            if (vecs[v].hold_press) check($sformatf("vec%0d_pulse_under_hold", v), int'(seen), int'(vecs[v].keys));
            if (vecs[v].do_tick) begin
                do_tick(vecs[v].hold_tick);
                run(2);
            end
            check($sformatf("vec%0d_dir", v), int'(dir), vecs[v].exp_dir);
            check($sformatf("vec%0d_pv", v), int'(pending_valid), vecs[v].exp_pv);
        end

        // Tick in the same cycle as a down press, pending=UP and dir=RIGHT.
        do_reset();
        press(4'b0001);
        key_down = 1'b1;
        found = 0;
        for (int n = 0; n < D + 10 && !found; n++) begin
            cycle();
            if (key_pulse[1]) found = 1;
        end
        check("same_cycle_pulse_seen", int'(found), 1);
        do_tick(1'b0);
        check("same_cycle_dir", int'(dir), 0);
        check("same_cycle_pv", int'(pending_valid), 1);
        key_down = 1'b0;
        run(D + 5);
        do_tick(1'b0);
        check("same_cycle_next_dir", int'(dir), 1);
        check("same_cycle_next_pv", int'(pending_valid), 0);

        // Asynchronous reset mid-count with a direction pending.
        do_reset();
        press(4'b0001);
        check("pre_rst_pv", int'(pending_valid), 1);
        key_left = 1'b1;
        run(100);
        rst = 1'b1;
        key_left = 1'b0;
        model_reset();
        #2;
        check("rst_async_dir", int'(dir), 3);
        check("rst_async_pv", int'(pending_valid), 0);
        check("rst_async_pulse", int'(key_pulse), 0);
        run(3);
        rst = 1'b0;
        seen = 4'b0;
        run(D + 20);
        check("rst_no_pulse_after", int'(seen), 0);

        // Random keys, ticks and hold against the model.
        do_reset();
        kv = 4'b0;
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 450);
        for (int n = 0; n < 15000; n++) begin
            for (int i = 0; i < 4; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    kv[i] = ~kv[i];
                    dur[i] = $urandom_range(1, 450);
                end
            end
            set_keys(kv);
            tick = ($urandom_range(0, 39) == 0);
            hold = ($urandom_range(0, 99) < 10);
            cycle();
        end
        tick = 1'b0; hold = 1'b0; set_keys(4'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
